// File: rtl/wb_stage.sv
// RV64 write-back stage: selects the retiring value, extracts load data from the
// returned doubleword, and drives the wdata/wrd/wopcode/we port of the register file.
module wb_stage #(
  parameter int XLEN         = 64,
  parameter int LOAD_TIMEOUT = 16,
  parameter int TO_W         = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_plus4,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] wdata,
  output logic [4:0]      wrd,
  output logic [6:0]      wopcode,
  output logic            we,
  output logic            align_err,
  output logic            timeout_err,
  output logic            illegal_op
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_NOP   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_OP32  = 7'b0111011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOAD_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            r_state, w_state_nx;
  logic [TO_W-1:0]   r_cnt, w_cnt_nx;
  logic [2:0]        r_f3, w_f3_nx;
  logic [2:0]        r_off, w_off_nx;
  logic [4:0]        r_rd, w_rd_nx;

  logic              w_we_nx, w_align_nx, w_to_nx, w_ill_nx;
  logic [4:0]        w_wrd_nx;
  logic [XLEN-1:0]   w_wdata_nx;
  logic [6:0]        w_wopc_nx;

  logic              w_accept, w_misalign;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_word;
  logic [XLEN-1:0]   w_ld_data;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready;

  // Natural alignment of the load size; func3=111 is screened out as illegal first.
  always_comb begin
    w_misalign = 1'b0;
    case (func3[1:0])
      2'b01:   w_misalign = alu_result[0];
      2'b10:   w_misalign = |alu_result[1:0];
      2'b11:   w_misalign = |alu_result[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  assign w_byte = mem_rdata[{r_off, 3'b000} +: 8];
  assign w_half = mem_rdata[{r_off[2:1], 4'b0000} +: 16];
  assign w_word = mem_rdata[{r_off[2], 5'b00000} +: 32];

  always_comb begin
    w_ld_data = mem_rdata;
    case (r_f3)
      3'b000:  w_ld_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b100:  w_ld_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b001:  w_ld_data = {{(XLEN-16){w_half[15]}}, w_half};
      3'b101:  w_ld_data = {{(XLEN-16){1'b0}}, w_half};
      3'b010:  w_ld_data = {{(XLEN-32){w_word[31]}}, w_word};
      3'b110:  w_ld_data = {{(XLEN-32){1'b0}}, w_word};
      default: w_ld_data = mem_rdata;
    endcase
  end

  // Next state and next registered outputs; idle cycles present a harmless NOP to x0.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_f3_nx    = r_f3;
    w_off_nx   = r_off;
    w_rd_nx    = r_rd;
    w_we_nx    = 1'b0;
    w_wrd_nx   = 5'd0;
    w_wdata_nx = '0;
    w_wopc_nx  = OP_NOP;
    w_align_nx = 1'b0;
    w_to_nx    = 1'b0;
    w_ill_nx   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_wopc_nx = opcode;
          case (opcode)
            OP_OP, OP_NOP, OP_OP32, OP_IMM32, OP_LUI, OP_AUIPC: begin
              w_we_nx    = 1'b1;
              w_wrd_nx   = rd;
              w_wdata_nx = alu_result;
            end
            OP_JAL, OP_JALR: begin
              w_we_nx    = 1'b1;
              w_wrd_nx   = rd;
              w_wdata_nx = pc_plus4;
            end
            OP_LOAD: begin
              if (func3 == 3'b111) begin
                w_ill_nx = 1'b1;
              end else if (w_misalign) begin
                w_align_nx = 1'b1;
              end else begin
                w_wopc_nx  = OP_NOP;
                w_f3_nx    = func3;
                w_rd_nx    = rd;
                w_off_nx   = alu_result[2:0];
                w_cnt_nx   = '0;
                w_state_nx = S_WAIT;
              end
            end
            OP_STORE, OP_BR: ;
            default: w_ill_nx = 1'b1;
          endcase
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          w_we_nx    = 1'b1;
          w_wrd_nx   = r_rd;
          w_wdata_nx = w_ld_data;
          w_wopc_nx  = OP_LOAD;
          w_state_nx = S_IDLE;
        end else if (r_cnt == TO_LAST) begin
          w_to_nx    = 1'b1;
          w_wopc_nx  = OP_LOAD;
          w_state_nx = S_IDLE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_f3        <= '0;
      r_off       <= '0;
      r_rd        <= '0;
      wdata       <= '0;
      wrd         <= '0;
      wopcode     <= OP_NOP;
      we          <= 1'b0;
      align_err   <= 1'b0;
      timeout_err <= 1'b0;
      illegal_op  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_f3        <= w_f3_nx;
      r_off       <= w_off_nx;
      r_rd        <= w_rd_nx;
      wdata       <= w_wdata_nx;
      wrd         <= w_wrd_nx;
      wopcode     <= w_wopc_nx;
      we          <= w_we_nx;
      align_err   <= w_align_nx;
      timeout_err <= w_to_nx;
      illegal_op  <= w_ill_nx;
    end
  end
endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the RV64 five-stage pipeline. It is the producer side of the ID register-file write port.
- Accepts retiring instructions from the MEM stage and waits for data-memory responses on loads.
- Extracts and sign/zero-extends load data, selects the write-back source, and drives the wdata/wrd/wopcode triple that the ID stage commits on the negedge.
- Guarantees x0 is targeted whenever an instruction must not write.

Parameters:
- XLEN, 64, datapath width
- LOAD_TIMEOUT, 16, max cycles in WAIT_MEM before timeout error
- TO_W, 5, width of timeout counter (must be ≥ clog2(LOAD_TIMEOUT+1))

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  MEM stage presents an instruction
- in_ready  output  1  stage can accept; transfer when in_valid&in_ready
- opcode  input  7  instruction opcode
- func3  input  3  load width/sign select
- rd  input  5  destination register
- alu_result  input  64  ALU result / load address
- pc_plus4  input  64  link value for jal/jalr
- mem_rvalid  input  1  data-memory response valid
- mem_rdata  input  64  aligned 64-bit doubleword containing load data
- wdata  output  64  write-back data to RF
- wrd  output  5  write-back register index
- wopcode  output  7  opcode of retiring instruction
- we  output  1  write strobe, one cycle per writing instruction
- align_err  output  1  one-cycle pulse on misaligned load
- timeout_err  output  1  one-cycle pulse on load timeout
- illegal_op  output  1  one-cycle pulse on unknown opcode

Behaviour:
- Reset: state=IDLE, wdata=0, wrd=0, wopcode=7'b0010011 (NOP), we=0, all error pulses 0, timeout counter 0. Reset mid-WAIT_MEM abandons the load with no write; a later mem_rvalid is ignored while in IDLE.
- in_ready=1 in IDLE only.
- IDLE, accept, non-load: outputs registered on the next posedge (latency 1). State stays IDLE. Back-to-back acceptance is allowed every cycle.
- IDLE, accept, load (0000011): latch func3, rd, and alu_result[2:0]; go to WAIT_MEM; counter cleared. During this cycle we=0, wrd=0, wopcode=NOP.
- WAIT_MEM: counter increments each cycle without mem_rvalid.
  - If mem_rvalid=1: register the extracted result, we=1, and return to IDLE (latency 1 after mem_rvalid).
  - mem_rvalid in the same cycle the counter reaches LOAD_TIMEOUT: data wins, no error.
  - Counter reaches LOAD_TIMEOUT without data: pulse timeout_err, no write, return to IDLE.
- Source select:
  - 0110011, 0010011, 0111011, 0011011, 0110111, 0010111 -> alu_result.
  - 1101111, 1100111 -> pc_plus4.
  - 0000011 -> load extract.
  - 0100011, 1100011 -> no write.
  - Any other opcode -> no write plus illegal_op pulse.
- No-write retire: we=0, wrd=0, wdata=0, wopcode=incoming opcode. This keeps the ID RF update harmless.
- rd=0 with a writing opcode: we=1, wrd=0, value passed through; RF forces x0=0.
- Load extract with offset o=addr[2:0]:
  - lb/lbu (000/100): byte at bits [8o+7:8o], sign- or zero-extended.
  - lh/lhu (001/101): halfword at o[2:1], sign- or zero-extended.
  - lw/lwu (010/110): word at o[2], sign- or zero-extended.
  - ld (011): full doubleword.
  - func3=111: treated as illegal_op, no write.
- Misaligned load: lh/lhu with o[0]≠0, lw/lwu with o[1:0]≠0, or ld with o≠0. Raised at acceptance: align_err pulses, no WAIT_MEM entry, no write, stay in IDLE.
- Error pulses last exactly one cycle and coincide with the no-write retire cycle.

Test Plan:
- Reset, then add x5 with alu_result=0x1234 and in_valid=1 -> next cycle we=1, wrd=5, wdata=0x1234, wopcode=0110011.
- lb to rd=7 with addr low bits=3, mem_rdata=0x00000000_80FF0000, mem_rvalid 2 cycles later -> in_ready=0 while waiting; cycle after rvalid: we=1, wrd=7, wdata=0xFFFFFFFF_FFFFFFFF? No, byte 3=0x80 -> wdata=0xFFFFFFFF_FFFFFF80. Repeat as lbu -> 0x80.
- lw with addr low bits=2 -> align_err pulse next cycle, we=0, wrd=0, state stays IDLE, in_ready stays 1.
- jal rd=1 with pc_plus4=0x1004 -> wdata=0x1004, wrd=1. sw rd field=9 -> we=0, wrd=0.
- ld with no mem_rvalid for 16 cycles -> timeout_err pulse, no write, in_ready returns to 1. Repeat with rvalid exactly on cycle 16 -> normal write, no error.
- Assert rst during WAIT_MEM, then assert mem_rvalid the cycle after rst deasserts -> no write; outputs hold reset values.
